mhp_tx_scheduler: RTL and testbench

- Round-robin scheduler that shares one MHP frame assembler among NUM_REQ requesters.
- Each requester supplies the MHP header fields plus payload.
- The block latches the winner's fields and pulses start to the assembler. It then waits for done, returns a per-requester ack, and enforces an inter-frame gap before the next grant.
- A watchdog aborts the grant if the assembler never reports done.

---
 rtl/mhp_pkg.sv | 17 +
 rtl/mhp_rr_arbiter.sv | 31 +++
 rtl/mhp_tx_scheduler.sv | 140 ++++++++++++++
 tb/tb_mhp_tx_scheduler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mhp_pkg.sv
// Shared MHP frame constants and scheduler state encodings.
package mhp_pkg;

    localparam int MHP_FRAME_LEN = 51;
    localparam int MHP_PAYLOAD_W = 336;
    localparam int MHP_ADDR_W    = 16;
    localparam int MHP_SIZE_W    = 16;
    localparam int MHP_TYPE_W    = 7;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } tx_state_t;

endpackage

// File: rtl/mhp_rr_arbiter.sv
// Combinational round-robin pick: first valid bit at or after ptr, modulo N.
module mhp_rr_arbiter
    import mhp_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant,
    output logic          any
);

    logic [IW:0] idx;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, ptr} + (IW+1)'(i);
            if (idx >= (IW+1)'(N))
                idx = idx - (IW+1)'(N);
            if (!any && valid[idx[IW-1:0]]) begin
                grant = idx[IW-1:0];
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mhp_tx_scheduler.sv
// Round-robin sharing of one MHP frame assembler among NUM_REQ requesters.
// Optional frame/timeout statistics ports: define MHP_TX_SCHED_STATS_EN.
module mhp_tx_scheduler
    import mhp_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [MHP_ADDR_W*NUM_REQ-1:0]    req_dst,
    input  logic [MHP_ADDR_W*NUM_REQ-1:0]    req_src,
    input  logic [MHP_SIZE_W*NUM_REQ-1:0]    req_size,
    input  logic [NUM_REQ-1:0]               req_dir,
    input  logic [MHP_TYPE_W*NUM_REQ-1:0]    req_type,
    input  logic [MHP_PAYLOAD_W*NUM_REQ-1:0] req_payload,
    output logic [NUM_REQ-1:0]               req_ack,
    output logic [NUM_REQ-1:0]               req_err,
    output logic                             fa_start,
    output logic [MHP_ADDR_W-1:0]            fa_dst,
    output logic [MHP_ADDR_W-1:0]            fa_src,
    output logic [MHP_SIZE_W-1:0]            fa_size,
    output logic                             fa_dir,
    output logic [MHP_TYPE_W-1:0]            fa_type,
    output logic [MHP_PAYLOAD_W-1:0]         fa_payload,
    input  logic                             fa_done,
    output logic                             busy,
    output logic [IW-1:0]                    grant_id
`ifdef MHP_TX_SCHED_STATS_EN
    ,
    output logic [31:0]                      stat_frames,
    output logic [15:0]                      stat_timeouts
`endif
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    tx_state_t     state;
    logic [IW-1:0] rr_ptr;
    logic [CW-1:0] tmo_cnt;
    logic [GW-1:0] gap_cnt;
    logic [IW-1:0] arb_grant;
    logic          arb_any;
    logic          ack_evt;
    logic          err_evt;
    logic [IW-1:0] next_ptr;

    mhp_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .any   (arb_any)
    );

    // done beats a coincident timeout
    assign ack_evt  = (state == ST_WAIT_DONE) && fa_done;
    assign err_evt  = (state == ST_WAIT_DONE) && !fa_done
                      && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign next_ptr = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            tmo_cnt    <= '0;
            gap_cnt    <= '0;
            grant_id   <= '0;
            req_ack    <= '0;
            req_err    <= '0;
            fa_start   <= 1'b0;
            fa_dst     <= '0;
            fa_src     <= '0;
            fa_size    <= '0;
            fa_dir     <= 1'b0;
            fa_type    <= '0;
            fa_payload <= '0;
        end else begin
            fa_start <= 1'b0;
            req_ack  <= '0;
            req_err  <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        fa_dst     <= req_dst[arb_grant*MHP_ADDR_W +: MHP_ADDR_W];
                        fa_src     <= req_src[arb_grant*MHP_ADDR_W +: MHP_ADDR_W];
                        fa_size    <= req_size[arb_grant*MHP_SIZE_W +: MHP_SIZE_W];
                        fa_dir     <= req_dir[arb_grant];
                        fa_type    <= req_type[arb_grant*MHP_TYPE_W +: MHP_TYPE_W];
                        fa_payload <= req_payload[arb_grant*MHP_PAYLOAD_W +: MHP_PAYLOAD_W];
                        grant_id   <= arb_grant;
                        state      <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    fa_start <= 1'b1;
                    tmo_cnt  <= '0;
                    state    <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (tmo_cnt != CW'(TIMEOUT_CYCLES))
                        tmo_cnt <= tmo_cnt + 1'b1;
                    if (ack_evt || err_evt) begin
                        req_ack[grant_id] <= ack_evt;
                        req_err[grant_id] <= err_evt;
                        rr_ptr  <= next_ptr;
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES - 1))
                        state <= ST_IDLE;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MHP_TX_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_frames   <= '0;
            stat_timeouts <= '0;
        end else begin
            if (ack_evt)
                stat_frames <= stat_frames + 1'b1;
            if (err_evt && stat_timeouts != 16'hFFFF)
                stat_timeouts <= stat_timeouts + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mhp_tx_scheduler.sv
// Directed self-checking bench for mhp_tx_scheduler (4 requesters, gap 2, timeout 64).
module tb_mhp_tx_scheduler;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req_valid;
    logic [63:0]   req_dst;
    logic [63:0]   req_src;
    logic [63:0]   req_size;
    logic [3:0]    req_dir;
    logic [27:0]   req_type;
    logic [1343:0] req_payload;
    logic [3:0]    req_ack;
    logic [3:0]    req_err;
    logic          fa_start;
    logic [15:0]   fa_dst;
    logic [15:0]   fa_src;
    logic [15:0]   fa_size;
    logic          fa_dir;
    logic [6:0]    fa_type;
    logic [335:0]  fa_payload;
    logic          fa_done;
    logic          busy;
    logic [1:0]    grant_id;
`ifdef MHP_TX_SCHED_STATS_EN
    logic [31:0]   stat_frames;
    logic [15:0]   stat_timeouts;
`endif

    int errors = 0;
    int checks = 0;
    logic [335:0] pay1;

    mhp_tx_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_dst     (req_dst),
        .req_src     (req_src),
        .req_size    (req_size),
        .req_dir     (req_dir),
        .req_type    (req_type),
        .req_payload (req_payload),
        .req_ack     (req_ack),
        .req_err     (req_err),
        .fa_start    (fa_start),
        .fa_dst      (fa_dst),
        .fa_src      (fa_src),
        .fa_size     (fa_size),
        .fa_dir      (fa_dir),
        .fa_type     (fa_type),
        .fa_payload  (fa_payload),
        .fa_done     (fa_done),
        .busy        (busy),
        .grant_id    (grant_id)
`ifdef MHP_TX_SCHED_STATS_EN
        ,
        .stat_frames   (stat_frames),
        .stat_timeouts (stat_timeouts)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [335:0] obs,
                       input logic [335:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // wait (bounded) for fa_start, check grant, return done after dly cycles
    task automatic serve(input int gid, input int dly);
        logic       found;
        logic [3:0] exp_ack;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (fa_start === 1'b1)
                found = 1'b1;
        end
        chk("start_seen", 336'(found), 336'(1));
        chk("grant_id", 336'(grant_id), 336'(gid));
        repeat (dly) tick();
        fa_done = 1'b1;
        tick();
        fa_done = 1'b0;
        exp_ack = 4'b0001 << gid;
        chk("serve_ack", 336'(req_ack), 336'(exp_ack));
        chk("serve_err", 336'(req_err), 336'(0));
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = '0;
        req_dst     = '0;
        req_src     = '0;
        req_size    = '0;
        req_dir     = '0;
        req_type    = '0;
        req_payload = '0;
        fa_done     = 1'b0;
        pay1        = {16'h5A5A, {10{32'hDEADBEEF}}};
        tick();
        tick();
        rst = 1'b0;

        chk("rst_busy", 336'(busy), 336'(0));
        chk("rst_start", 336'(fa_start), 336'(0));
        chk("rst_grant", 336'(grant_id), 336'(0));
        chk("rst_ack", 336'(req_ack), 336'(0));
        chk("rst_dst", 336'(fa_dst), 336'(0));
        chk("rst_payload", fa_payload, 336'(0));

        // all four valid: order 0,1,2,3,0
        req_valid = 4'hF;
        serve(0, 3);
        serve(1, 3);
        serve(2, 3);
        serve(3, 3);
        serve(0, 3);
        req_valid = 4'h0;
        tick();
        tick();
        chk("rot_idle", 336'(busy), 336'(0));

        // single request from requester 1, exact latency
        req_dst[31:16]    = 16'h1234;
        req_src[31:16]    = 16'hABCD;
        req_size[31:16]   = 16'h0033;
        req_dir[1]        = 1'b1;
        req_type[13:7]    = 7'h05;
        req_payload[671:336] = pay1;
        req_valid = 4'b0010;
        tick();
        chk("s_launch_busy", 336'(busy), 336'(1));
        chk("s_launch_start", 336'(fa_start), 336'(0));
        chk("s_grant", 336'(grant_id), 336'(1));
        chk("s_dst", 336'(fa_dst), 336'(16'h1234));
        chk("s_src", 336'(fa_src), 336'(16'hABCD));
        chk("s_size", 336'(fa_size), 336'(16'h0033));
        chk("s_dir", 336'(fa_dir), 336'(1));
        chk("s_type", 336'(fa_type), 336'(7'h05));
        chk("s_payload", fa_payload, pay1);
        tick();
        chk("s_start_t2", 336'(fa_start), 336'(1));
        req_dst[31:16] = 16'h0000;
        tick();
        chk("s_start_once", 336'(fa_start), 336'(0));
        chk("s_dst_hold", 336'(fa_dst), 336'(16'h1234));
        repeat (51) tick();
        fa_done = 1'b1;
        tick();
        fa_done   = 1'b0;
        req_valid = 4'b0000;
        chk("s_ack", 336'(req_ack), 336'(4'b0010));
        chk("s_err", 336'(req_err), 336'(0));
        chk("s_gap1_busy", 336'(busy), 336'(1));
        tick();
        chk("s_ack_pulse", 336'(req_ack), 336'(0));
        chk("s_gap2_busy", 336'(busy), 336'(1));
        tick();
        chk("s_idle", 336'(busy), 336'(0));

        // timeout on requester 3, stale done ignored
        req_valid = 4'b1000;
        tick();
        tick();
        chk("t_start", 336'(fa_start), 336'(1));
        chk("t_grant", 336'(grant_id), 336'(3));
        repeat (63) tick();
        chk("t_no_err_early", 336'(req_err), 336'(0));
        tick();
        chk("t_err", 336'(req_err), 336'(4'b1000));
        chk("t_no_ack", 336'(req_ack), 336'(0));
        req_valid = 4'b0000;
        fa_done   = 1'b1;
        tick();
        fa_done = 1'b0;
        chk("t_stale_gap", 336'(req_ack), 336'(0));
        chk("t_err_pulse", 336'(req_err), 336'(0));
        fa_done = 1'b1;
        tick();
        fa_done = 1'b0;
        chk("t_idle", 336'(busy), 336'(0));
        tick();
        chk("t_stale_idle", 336'(req_ack), 336'(0));
        chk("t_stay_idle", 336'(busy), 336'(0));

        // done on the timeout cycle: ack wins
        req_valid = 4'b0001;
        tick();
        tick();
        chk("d_start", 336'(fa_start), 336'(1));
        chk("d_grant", 336'(grant_id), 336'(0));
        repeat (63) tick();
        fa_done = 1'b1;
        tick();
        fa_done   = 1'b0;
        req_valid = 4'b0000;
        chk("d_ack", 336'(req_ack), 336'(4'b0001));
        chk("d_no_err", 336'(req_err), 336'(0));
        tick();
        tick();
`ifdef MHP_TX_SCHED_STATS_EN
        chk("st_frames", 336'(stat_frames), 336'(7));
        chk("st_timeouts", 336'(stat_timeouts), 336'(1));
`endif

        // reset during WAIT_DONE
        req_valid = 4'b0100;
        tick();
        tick();
        chk("r_grant_pre", 336'(grant_id), 336'(2));
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("r_busy", 336'(busy), 336'(0));
        chk("r_start", 336'(fa_start), 336'(0));
        chk("r_grant", 336'(grant_id), 336'(0));
        chk("r_dst", 336'(fa_dst), 336'(0));
        chk("r_ack", 336'(req_ack), 336'(0));
        chk("r_err", 336'(req_err), 336'(0));
`ifdef MHP_TX_SCHED_STATS_EN
        chk("r_st_frames", 336'(stat_frames), 336'(0));
`endif
        serve(2, 4);
        req_valid = 4'b0000;
        tick();
        tick();

        // rr_ptr is 3 now: requesters 0 and 2 valid -> 0 next
        req_valid = 4'b0101;
        serve(0, 2);
        req_valid = 4'b0000;
        tick();
        tick();
        chk("end_idle", 336'(busy), 336'(0));
`ifdef MHP_TX_SCHED_STATS_EN
        chk("end_st_frames", 336'(stat_frames), 336'(2));
        chk("end_st_timeouts", 336'(stat_timeouts), 336'(0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
